// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: six patterns behind a 2-stage p_tick pipeline.
// Mode and user colour are sampled only at frame start so frames never tear.
module vga_pattern_gen #(
    parameter int CB         = 4,
    parameter int COORD_W    = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BAR_W      = 80,
    parameter int CHK_LOG2   = 5,
    parameter int GRAD_SHIFT = 5,
    parameter int BOX_SIZE   = 32,
    parameter int BOX_STEP   = 2
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [2:0]         mode,
    input  logic [3*CB-1:0]    sw,
    output logic               hsync,
    output logic               vsync,
    output logic [3*CB-1:0]    rgb,
    output logic [15:0]        frame_cnt
);
    localparam int RW = 3 * CB;
    localparam logic [CB-1:0]      FULL     = '1;
    localparam logic [COORD_W-1:0] LVL_MAX  = COORD_W'((1 << CB) - 1);
    localparam logic [COORD_W-1:0] STEP     = COORD_W'(BOX_STEP);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W:0]   SPAN     = (COORD_W + 1)'(BOX_SIZE + BOX_STEP);
    localparam logic [COORD_W:0]   BSZ      = (COORD_W + 1)'(BOX_SIZE);
    localparam logic [COORD_W:0]   H_LIM    = (COORD_W + 1)'(H_ACTIVE);
    localparam logic [COORD_W:0]   V_LIM    = (COORD_W + 1)'(V_ACTIVE);

    logic [2:0]         mode_s1, mode_s2, mode_q;
    logic [RW-1:0]      sw_s1, sw_s2, sw_q;
    logic [COORD_W-1:0] bx, by;
    logic               dir_x, dir_y;
    logic [COORD_W:0]   nx, ny;
    logic               fs;

    logic               vo1, hs1, vs1;
    logic [COORD_W-1:0] x1, y1, px_cnt;
    logic [2:0]         bar1;

    logic [RW-1:0]      pat;
    logic [2:0]         bar_c;
    logic [COORD_W-1:0] lvl;
    logic [CB-1:0]      gl;
    logic               in_box;

    // Returns {dir, pos}; dir 0 = moving up-count, 1 = moving down-count.
    function automatic logic [COORD_W:0] axis_step(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [COORD_W:0]   lim
    );
        if (!dir) begin
            if ({1'b0, pos} + SPAN > lim)
                return {1'b1, pos - STEP};
            return {1'b0, pos + STEP};
        end
        if (pos < STEP)
            return {1'b0, pos + STEP};
        return {1'b1, pos - STEP};
    endfunction

    assign nx = axis_step(bx, dir_x, H_LIM);
    assign ny = axis_step(by, dir_y, V_LIM);
    assign fs = p_tick & video_on & (x == '0) & (y == '0);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            mode_s1 <= '0;
            mode_s2 <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            mode_q    <= '0;
            sw_q      <= '0;
            frame_cnt <= '0;
            bx        <= '0;
            by        <= '0;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
        end else if (fs) begin
            mode_q       <= mode_s2;
            sw_q         <= sw_s2;
            frame_cnt    <= frame_cnt + 16'd1;
            {dir_x, bx}  <= nx;
            {dir_y, by}  <= ny;
        end
    end

    // Stage 1: capture timing and track the colour-bar index along the line.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            vo1    <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            x1     <= '0;
            y1     <= '0;
            px_cnt <= '0;
            bar1   <= '0;
        end else if (p_tick) begin
            vo1 <= video_on;
            hs1 <= hsync_in;
            vs1 <= vsync_in;
            x1  <= x;
            y1  <= y;
            if (x == '0) begin
                px_cnt <= '0;
                bar1   <= '0;
            end else if (px_cnt == BAR_LAST) begin
                px_cnt <= '0;
                if (bar1 != 3'd7)
                    bar1 <= bar1 + 3'd1;
            end else begin
                px_cnt <= px_cnt + ONE;
            end
        end
    end

    always_comb begin
        pat    = '0;
        bar_c  = 3'd7 - bar1;
        lvl    = x1 >> GRAD_SHIFT;
        gl     = (lvl > LVL_MAX) ? FULL : lvl[CB-1:0];
        in_box = ({1'b0, x1} >= {1'b0, bx}) && ({1'b0, x1} < {1'b0, bx} + BSZ) &&
                 ({1'b0, y1} >= {1'b0, by}) && ({1'b0, y1} < {1'b0, by} + BSZ);
        case (mode_q)
            3'd0: pat = sw_q;
            3'd1: pat = {{CB{bar_c[1]}}, {CB{bar_c[2]}}, {CB{bar_c[0]}}};
            3'd2: pat = {gl, gl, gl};
            3'd3: pat = (x1[CHK_LOG2] ^ y1[CHK_LOG2]) ? sw_q : '0;
            3'd4: pat = in_box ? sw_q : '0;
            3'd5: pat = (x1 == '0 || x1 == X_LAST || y1 == '0 || y1 == Y_LAST) ?
                        {RW{1'b1}} : '0;
            default: pat = '0;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            rgb   <= '0;
        end else if (p_tick) begin
            hsync <= hs1;
            vsync <= vs1;
            rgb   <= vo1 ? pat : '0;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: scoreboard queue of expected
// pixels plus a table of fixed pattern vectors and reset/mode-change sequences.
module tb_vga_pattern_gen;
    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x, y;
    logic        hsync_in, vsync_in;
    logic [2:0]  mode;
    logic [11:0] sw;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic [15:0] frame_cnt;

    vga_pattern_gen dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mode       (mode),
        .sw         (sw),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } sb_t;

    typedef struct {
        logic [2:0]  md;
        int          xx;
        int          yy;
        logic [11:0] exp;
    } vec_t;

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    sb_t         sbq[$];
    vec_t        tbl[19];
    int          n_chk = 0;
    int          n_pass = 0;

    logic [2:0]  m_mode;
    logic [11:0] m_sw;
    logic [15:0] m_fcnt;
    int          m_bx, m_by;
    bit          m_dx, m_dy;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        sb_t c;
        m_mode = 3'd0;
        m_sw   = 12'h000;
        m_fcnt = 16'd0;
        m_bx = 0; m_by = 0; m_dx = 1'b0; m_dy = 1'b0;
        c.rgb = 12'h000; c.hs = 1'b0; c.vs = 1'b0;
        sbq.delete();
        sbq.push_back(c);
    endtask

    task automatic step_axis(inout int p, inout bit d, input int lim);
        if (!d) begin
            if (p + 32 + 2 > lim) begin d = 1'b1; p -= 2; end
            else p += 2;
        end else if (p < 2) begin
            d = 1'b0; p += 2;
        end else begin
            p -= 2;
        end
    endtask

    function automatic logic [11:0] model_rgb(input int xx, input int yy, input logic vo);
        int g;
        int bi;
        if (!vo) return 12'h000;
        case (m_mode)
            3'd0: return m_sw;
            3'd1: begin
                bi = xx / 80;
                if (bi > 7) bi = 7;
                return BARS[bi];
            end
            3'd2: begin
                g = xx >> 5;
                if (g > 15) g = 15;
                return {g[3:0], g[3:0], g[3:0]};
            end
            3'd3: return ((((xx >> 5) ^ (yy >> 5)) & 1) != 0) ? m_sw : 12'h000;
            3'd4: return (xx >= m_bx && xx < m_bx + 32 &&
                          yy >= m_by && yy < m_by + 32) ? m_sw : 12'h000;
            3'd5: return (xx == 0 || xx == 639 || yy == 0 || yy == 479) ?
                         12'hFFF : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic pix(input int xx, input int yy, input logic [11:0] texp, input bit use_tbl);
        logic vo;
        sb_t  e;
        sb_t  o;
        vo = (xx < 640) && (yy < 480);
        @(negedge clk_100MHz);
        p_tick   = 1'b1;
        video_on = vo;
        x        = xx[9:0];
        y        = yy[9:0];
        hsync_in = !(xx >= 656 && xx < 752);
        vsync_in = !(yy >= 490 && yy < 492);
        if (vo && xx == 0 && yy == 0) begin
            m_mode = mode;
            m_sw   = sw;
            m_fcnt = m_fcnt + 16'd1;
            step_axis(m_bx, m_dx, 640);
            step_axis(m_by, m_dy, 480);
        end
        e.rgb = use_tbl ? texp : model_rgb(xx, yy, vo);
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        sbq.push_back(e);
        @(negedge clk_100MHz);
        p_tick = 1'b0;
        o = sbq.pop_front();
        chk("rgb", 16'(rgb), 16'(o.rgb));
        chk("hsync", 16'(hsync), 16'(o.hs));
        chk("vsync", 16'(vsync), 16'(o.vs));
        chk("frame_cnt", frame_cnt, m_fcnt);
        repeat (2) @(negedge clk_100MHz);
        chk("rgb_hold", 16'(rgb), 16'(o.rgb));
    endtask

    task automatic sweep(input int yy, input int x0, input int x1);
        for (int i = x0; i <= x1; i++) pix(i, yy, 12'h000, 1'b0);
    endtask

    task automatic set_mode(input logic [2:0] m);
        mode = m;
        repeat (4) @(negedge clk_100MHz);
    endtask

    task automatic frame_start();
        pix(0, 0, 12'h000, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{3'd0,  10,  10, 12'hF80};
        tbl[1]  = '{3'd0, 700,  10, 12'h000};
        tbl[2]  = '{3'd2,   0,  10, 12'h000};
        tbl[3]  = '{3'd2,  32,  10, 12'h111};
        tbl[4]  = '{3'd2, 100,  10, 12'h333};
        tbl[5]  = '{3'd2, 480,  10, 12'hFFF};
        tbl[6]  = '{3'd2, 639,  10, 12'hFFF};
        tbl[7]  = '{3'd3,   5,   5, 12'h000};
        tbl[8]  = '{3'd3,  32,   5, 12'hF80};
        tbl[9]  = '{3'd3,  32,  32, 12'h000};
        tbl[10] = '{3'd3,   5,  40, 12'hF80};
        tbl[11] = '{3'd5,   0, 100, 12'hFFF};
        tbl[12] = '{3'd5, 639, 100, 12'hFFF};
        tbl[13] = '{3'd5, 320,   0, 12'hFFF};
        tbl[14] = '{3'd5, 320, 479, 12'hFFF};
        tbl[15] = '{3'd5, 320, 240, 12'h000};
        tbl[16] = '{3'd5, 638, 478, 12'h000};
        tbl[17] = '{3'd5, 700,   0, 12'h000};
        tbl[18] = '{3'd6,  10,  10, 12'h000};

        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0;
        x = '0; y = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        mode = 3'd0; sw = 12'h000;
        repeat (3) @(negedge clk_100MHz);
        chk("reset_rgb", 16'(rgb), 16'h0000);
        chk("reset_hsync", 16'(hsync), 16'h0000);
        chk("reset_vsync", 16'(vsync), 16'h0000);
        chk("reset_frame_cnt", frame_cnt, 16'h0000);
        reset = 1'b0;
        model_reset();

        // Solid colour over two abbreviated frames with blanking and syncs.
        sw = 12'hF80;
        set_mode(3'd0);
        for (int f = 0; f < 2; f++) begin
            frame_start();
            sweep(0, 1, 799);
            sweep(479, 600, 799);
            sweep(490, 0, 15);
        end

        // Colour bars along one full line.
        set_mode(3'd1);
        frame_start();
        sweep(5, 0, 799);

        // Fixed pattern vectors.
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].md != mode) begin
                set_mode(tbl[i].md);
                frame_start();
            end
            pix(tbl[i].xx, tbl[i].yy, tbl[i].exp, 1'b1);
        end

        // Bouncing box through both edge reversals.
        set_mode(3'd4);
        for (int f = 0; f < 331; f++) begin
            frame_start();
            pix(m_bx, m_by, 12'h000, 1'b0);
            pix(m_bx + 31, m_by + 31, 12'h000, 1'b0);
            pix(m_bx + 32, m_by, 12'h000, 1'b0);
            pix(m_bx, m_by + 32, 12'h000, 1'b0);
        end

        // Mode change mid-frame only takes effect at the next frame start.
        set_mode(3'd0);
        frame_start();
        pix(40, 200, 12'hF80, 1'b1);
        set_mode(3'd3);
        pix(41, 200, 12'hF80, 1'b1);
        pix(5, 300, 12'hF80, 1'b1);
        frame_start();
        pix(5, 5, 12'h000, 1'b1);
        pix(32, 5, 12'hF80, 1'b1);

        // Reset mid-frame, then recovery at the next frame start.
        set_mode(3'd0);
        frame_start();
        pix(299, 100, 12'hF80, 1'b1);
        pix(300, 100, 12'hF80, 1'b1);
        @(negedge clk_100MHz);
        reset = 1'b1;
        #1;
        chk("midreset_rgb", 16'(rgb), 16'h0000);
        chk("midreset_frame_cnt", frame_cnt, 16'h0000);
        chk("midreset_hsync", 16'(hsync), 16'h0000);
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        model_reset();
        pix(301, 100, 12'h000, 1'b1);
        pix(302, 100, 12'h000, 1'b1);
        pix(303, 100, 12'h000, 1'b1);
        frame_start();
        pix(10, 10, 12'hF80, 1'b1);
        pix(11, 10, 12'hF80, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
